// File: rtl/hex_disp_pkg.sv
// Shared constants and seven-segment decode for the multiplexed hex display.
package hex_disp_pkg;

   localparam int NUM_DIGITS = 6;
   localparam logic [6:0] SEG_OFF = 7'h7F;
   localparam logic [5:0] AN_OFF  = 6'h3F;

   // Active-low segments, bit6 = a ... bit0 = g.
   function automatic logic [6:0] hex7seg(input logic [3:0] nibble);
      logic [6:0] seg;
      case (nibble)
         4'h0:    seg = 7'b0000001;
         4'h1:    seg = 7'b1001111;
         4'h2:    seg = 7'b0010010;
         4'h3:    seg = 7'b0000110;
         4'h4:    seg = 7'b1001100;
         4'h5:    seg = 7'b0100100;
         4'h6:    seg = 7'b0100000;
         4'h7:    seg = 7'b0001111;
         4'h8:    seg = 7'b0000000;
         4'h9:    seg = 7'b0001100;
         4'hA:    seg = 7'b0001000;
         4'hB:    seg = 7'b1100000;
         4'hC:    seg = 7'b0110001;
         4'hD:    seg = 7'b1000010;
         4'hE:    seg = 7'b0110000;
         default: seg = 7'b0111000;
      endcase
      return seg;
   endfunction

   // Digit k shows snap[4k+3:4k]; HEX5..HEX4 carry the PC byte.
   function automatic logic [3:0] digit_nibble(input logic [23:0] snap,
                                               input logic [2:0]  digit);
      logic [3:0] nib;
      case (digit)
         3'd0:    nib = snap[3:0];
         3'd1:    nib = snap[7:4];
         3'd2:    nib = snap[11:8];
         3'd3:    nib = snap[15:12];
         3'd4:    nib = snap[19:16];
         default: nib = snap[23:20];
      endcase
      return nib;
   endfunction

endpackage

// File: rtl/hex_display_scanner_scan_timer.sv
// Slot divider and digit counter; exposes current and next-cycle scan position.
module scan_timer
   import hex_disp_pkg::*;
#(
   parameter int DIV   = 50000,
   parameter int BLANK = 2,
   parameter int CW    = $clog2(DIV)
) (
   input  logic          clock,
   input  logic          reset,
   output logic [CW-1:0] div_cnt,
   output logic [2:0]    digit,
   output logic          slot_blank,
   output logic          frame_end,
   output logic [2:0]    digit_next,
   output logic          blank_next
);

   localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 1);
   localparam logic [CW-1:0] BLANK_C    = CW'(BLANK);
   localparam logic [2:0]    DIGIT_LAST = 3'(NUM_DIGITS - 1);

   logic [CW-1:0] div_next;
   logic          slot_end;

   assign slot_end = (div_cnt == DIV_LAST);

   always_comb begin
      div_next   = div_cnt + 1'b1;
      digit_next = digit;
      if (slot_end) begin
         div_next   = '0;
         digit_next = (digit == DIGIT_LAST) ? 3'd0 : digit + 3'd1;
      end
   end

   // Output registers downstream are loaded from the next position, so they
   // need the blanking decision one cycle early.
   assign blank_next = (BLANK != 0) && (div_next < BLANK_C);
   assign slot_blank = (BLANK != 0) && (div_cnt < BLANK_C);
   assign frame_end  = slot_end && (digit == DIGIT_LAST);

   always_ff @(posedge clock) begin
      if (!reset) begin
         div_cnt <= '0;
         digit   <= 3'd0;
      end else begin
         div_cnt <= div_next;
         digit   <= digit_next;
      end
   end

endmodule

// File: rtl/hex_display_scanner.sv
// Six-digit multiplexed hex display of PC[7:0] and WD[15:0] with tear-free
// frame-boundary capture, req/ack or free-running.
module hex_display_scanner
   import hex_disp_pkg::*;
#(
   parameter int DIV   = 50000,
   parameter int BLANK = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] pc_val,
   input  logic [31:0] wd_val,
   input  logic        cap_req,
   input  logic        live,
   output logic [6:0]  seg,
   output logic [5:0]  an,
   output logic        cap_ack,
   output logic        frame_done
);

   localparam int CW = $clog2(DIV);

   logic [CW-1:0] div_cnt;
   logic [2:0]    digit;
   logic          slot_blank;
   logic          frame_end;
   logic [2:0]    digit_next;
   logic          blank_next;
   logic [23:0]   snap;
   logic [23:0]   snap_next;

   scan_timer #(
      .DIV   (DIV),
      .BLANK (BLANK),
      .CW    (CW)
   ) u_scan_timer (
      .clock      (clock),
      .reset      (reset),
      .div_cnt    (div_cnt),
      .digit      (digit),
      .slot_blank (slot_blank),
      .frame_end  (frame_end),
      .digit_next (digit_next),
      .blank_next (blank_next)
   );

   // Only the boundary cycle may load the snapshot, so a frame never tears.
   always_comb begin
      snap_next = snap;
      if (frame_end && (cap_req || live))
         snap_next = {pc_val[7:0], wd_val[15:0]};
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         snap       <= '0;
         seg        <= SEG_OFF;
         an         <= AN_OFF;
         cap_ack    <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         snap       <= snap_next;
         cap_ack    <= frame_end && cap_req;
         frame_done <= frame_end;
         if (blank_next) begin
            seg <= SEG_OFF;
            an  <= AN_OFF;
         end else begin
            seg <= hex7seg(digit_nibble(snap_next, digit_next));
            an  <= AN_OFF ^ (6'b000001 << digit_next);
         end
      end
   end

   logic unused_ok;
   assign unused_ok = ^{pc_val[31:8], wd_val[31:16], slot_blank, div_cnt, digit};

endmodule

// File: tb/tb_hex_display_scanner.sv
// Randomized bench for hex_display_scanner against a cycle-count reference model.
module tb_hex_display_scanner;

   localparam int DIV   = 8;
   localparam int BLANK = 2;
   localparam int FRAME = 6 * DIV;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] pc_val;
   logic [31:0] wd_val;
   logic        cap_req;
   logic        live;
   logic [6:0]  seg;
   logic [5:0]  an;
   logic        cap_ack;
   logic        frame_done;

   always #5 clock = ~clock;

   hex_display_scanner #(
      .DIV   (DIV),
      .BLANK (BLANK)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .pc_val     (pc_val),
      .wd_val     (wd_val),
      .cap_req    (cap_req),
      .live       (live),
      .seg        (seg),
      .an         (an),
      .cap_ack    (cap_ack),
      .frame_done (frame_done)
   );

   int tests = 0;
   int fails = 0;

   // Reference: position is derived from the cycle count since reset release.
   logic [6:0]  seg_table [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
   int          t;
   logic [23:0] m_snap;
   bit          m_rst;
   bit          m_ack;
   bit          m_fd;
   int          m_dig;
   int          m_pos;
   int          acks;
   int          fds;
   int          exp_fds;
   int          last_fd;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      logic        r, q, l, boundary;
      logic [31:0] p, w;
      logic [6:0]  e_seg;
      logic [5:0]  e_an;
      r = reset; q = cap_req; l = live; p = pc_val; w = wd_val;
      @(posedge clock);
      #1;
      if (!r) begin
         t = 0; m_snap = '0; m_ack = 0; m_fd = 0; m_rst = 1; last_fd = -1;
      end else begin
         boundary = ((t % FRAME) == FRAME - 1);
         if (boundary && (q || l)) m_snap = {p[7:0], w[15:0]};
         m_ack = boundary && q;
         m_fd  = boundary;
         t++;
         m_rst = 0;
      end
      m_pos = t % DIV;
      m_dig = (t / DIV) % 6;
      if (m_rst || m_pos < BLANK) begin
         e_seg = 7'h7F;
         e_an  = 6'h3F;
      end else begin
         e_seg = seg_table[m_snap[4*m_dig +: 4]];
         e_an  = 6'h3F & ~(6'b000001 << m_dig);
      end
      check("seg", 32'(seg), 32'(e_seg));
      check("an", 32'(an), 32'(e_an));
      check("cap_ack", 32'(cap_ack), 32'(m_ack));
      check("frame_done", 32'(frame_done), 32'(m_fd));
      if (m_fd) exp_fds++;
      if (cap_ack) acks++;
      if (frame_done) begin
         fds++;
         if (last_fd >= 0) check("fd_period", 32'(t - last_fd), 32'(FRAME));
         last_fd = t;
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic run_to_digit(input int d);
      int n = 0;
      while (!(m_dig == d && m_pos == 0) && n < 2 * FRAME) begin
         step();
         n++;
      end
   endtask

   // Requester holds cap_req until it sees cap_ack, then drops it.
   task automatic request(input int max_cycles);
      int n = 0;
      bit got = 0;
      cap_req = 1'b1;
      while (!got && n < max_cycles) begin
         step();
         n++;
         if (cap_ack === 1'b1) begin
            got = 1;
            check("ack_with_frame_done", 32'(frame_done), 32'd1);
         end
      end
      check("ack_timeout", 32'(got), 32'd1);
      cap_req = 1'b0;
   endtask

   logic [6:0] hs_seg [6] = '{7'b0110001, 7'b0000110, 7'b0111000,
                              7'b1001111, 7'b1001100, 7'b0001000};
   int a0;

   initial begin
      reset = 1'b0; pc_val = '0; wd_val = '0; cap_req = 1'b0; live = 1'b0;
      t = 0; m_snap = '0; m_rst = 1; m_ack = 0; m_fd = 0; m_dig = 0; m_pos = 0;
      acks = 0; fds = 0; exp_fds = 0; last_fd = -1;

      // 1. Reset and first visible digit.
      run(3);
      check("rst_seg", 32'(seg), 32'h7F);
      check("rst_an", 32'(an), 32'h3F);
      reset = 1'b1;
      run(2);
      check("first_an", 32'(an), 32'h3E);
      check("first_seg", 32'(seg), 32'(7'b0000001));

      // 2. Handshake raised mid-frame.
      run_to_digit(2);
      pc_val = 32'h0000_00A4;
      wd_val = 32'h0000_1F3C;
      a0 = acks;
      request(2 * FRAME);
      check("hs_ack_once", 32'(acks - a0), 32'd1);
      pc_val = $urandom;
      wd_val = $urandom;
      for (int i = 0; i < FRAME; i++) begin
         step();
         if (m_pos >= BLANK) check("hs_digit", 32'(seg), 32'(hs_seg[m_dig]));
      end
      check("hs_ack_after", 32'(acks - a0), 32'd1);

      // 3. Free scan with random input noise and no capture.
      fds = 0; exp_fds = 0;
      for (int i = 0; i < 200; i++) begin
         pc_val = $urandom;
         wd_val = $urandom;
         step();
      end
      check("fd_count", 32'(fds), 32'(exp_fds));
      check("fd_count_range", 32'(fds >= 4 && fds <= 5), 32'd1);

      // 4. Live mode, wd incrementing each frame.
      live = 1'b1;
      a0 = acks;
      pc_val = $urandom;
      wd_val = $urandom;
      for (int f = 0; f < 5; f++) begin
         for (int i = 0; i < FRAME; i++) step();
         wd_val = wd_val + 1;
         pc_val = 32'($urandom_range(0, 255));
      end
      check("live_no_ack", 32'(acks - a0), 32'd0);
      live = 1'b0;

      // 5. Reset mid-operation with a pending request.
      run_to_digit(3);
      cap_req = 1'b1;
      reset = 1'b0;
      run(2);
      check("midrst_an", 32'(an), 32'h3F);
      reset = 1'b1;
      cap_req = 1'b0;
      a0 = acks;
      run(2 * FRAME + 5);
      check("midrst_no_ack", 32'(acks - a0), 32'd0);

      // 6. Request together with live mode.
      live = 1'b1;
      pc_val = $urandom;
      wd_val = $urandom;
      run_to_digit($urandom_range(0, 5));
      a0 = acks;
      request(2 * FRAME);
      live = 1'b0;
      run(FRAME + 3);
      check("sim_ack_once", 32'(acks - a0), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/hex_display_scanner.md
# hex_display_scanner

Time-multiplexed driver that shares one active-low seven-segment bus among the six board digits showing the MIPS core's `PC_val[7:0]` (HEX5..HEX4) and `WD_val[15:0]` (HEX3..HEX0). It samples both values into a 24-bit snapshot only at frame boundaries, so a displayed frame never tears. It then scans the digits with a programmable dwell and inter-digit blanking. Captures are on demand (req/ack handshake) or free-running (`live`). The block sits between the `mips` top-level outputs and the board pins.

## Interface
- `DIV`, 50000: clock cycles per digit slot; legal range DIV ≥ 2.
- `BLANK`, 2: cycles at the start of each slot with all digits off (anti-ghosting); legal range 0 ≤ BLANK < DIV.
- `clock` input, 1 bit: single clock, all state on posedge.
- `reset` input, 1 bit: synchronous, active-low.
- `pc_val` input, 32 bits: core PC; only [7:0] is used.
- `wd_val` input, 32 bits: core write-data; only [15:0] is used.
- `cap_req` input, 1 bit: capture request; held high until `cap_ack`.
- `live` input, 1 bit: 1 = capture at every frame boundary, no ack.
- `seg` output, 7 bits: segment drive, active-low, bit6=a … bit0=g.
- `an` output, 6 bits: digit enable, active-low; `an[k]` selects digit k (HEXk).
- `cap_ack` output, 1 bit: one-cycle pulse, request served.
- `frame_done` output, 1 bit: one-cycle pulse per completed frame.

## Operation
- State:
  - `div_cnt` is [$clog2(DIV)-1:0] wide and counts 0..DIV-1.
  - `digit` is 3 bits and counts 0..5.
  - `snap` is 24 bits and holds {pc[7:0], wd[15:0]}.
- Scan behaviour:
  - `div_cnt` increments every cycle.
  - When `div_cnt`==DIV-1, it returns to 0 and `digit` advances; digit 5 wraps to 0.
- Nibble map (digit → `snap` bits):
  - 5 → [23:20], 4 → [19:16], 3 → [15:12]
  - 2 → [11:8], 1 → [7:4], 0 → [3:0]
- Decode, active-low, nibble 0..F:
  - 0–3: 0000001, 1001111, 0010010, 0000110
  - 4–7: 1001100, 0100100, 0100000, 0001111
  - 8–B: 0000000, 0001100, 0001000, 1100000
  - C–F: 0110001, 1000010, 0110000, 0111000
- Blanking:
  - While `div_cnt` < BLANK: `an`=6'b111111 and `seg`=7'b1111111.
  - Otherwise: `an` has only bit `digit` low, and `seg`=decode(nibble).
- Frame boundary is the cycle with `digit`==5 and `div_cnt`==DIV-1. On that edge:
  - If `cap_req`|`live`: `snap` ← {pc_val[7:0], wd_val[15:0]} sampled in that cycle.
  - `frame_done` ← 1 for the next cycle.
  - `cap_ack` ← `cap_req` (1 for the next cycle only, regardless of `live`).
- Requests outside a boundary are not latched. The requester must hold `cap_req` until it sees `cap_ack`, then drop it. The next boundary is ≥6·DIV cycles away, so double capture cannot occur.
- Reset (`reset`==0 at posedge):
  - `div_cnt`=0, `digit`=0, `snap`=0.
  - `seg`=7'h7F, `an`=6'h3F, `cap_ack`=0, `frame_done`=0.
  - Applies mid-frame too; any outstanding request is dropped without ack.

## Timing
- `seg`/`an` are registers loaded from next-state values. In cycle n they reflect (`digit`, `div_cnt`, `snap`) of cycle n, with no combinational path from inputs.
- Cycle-level timing:
  - Frame length: 6·DIV cycles.
  - `frame_done` period: 6·DIV cycles.
  - `cap_ack`: 1 cycle after the boundary.
  - The new `snap` first appears on digit 0 BLANK cycles after the boundary.
- First visible digit after reset release: digit 0 at cycle BLANK.
- BLANK=0 means no blank cycles. `seg` never shows a decoded value while `an`=3F.

## Structure
- Package `hex_disp_pkg`:
  - `function logic [6:0] hex7seg(logic [3:0])` implementing the decode table above.
  - `localparam NUM_DIGITS = 6`.
  - `SEG_OFF = 7'h7F` and `AN_OFF = 6'h3F`.
- The package decode replaces the per-digit case chains currently written in benches.
- One natural sub-module, `scan_timer`: holds `div_cnt` and `digit` and emits `slot_blank`, `frame_end`. The capture/handshake logic and output registers live in `hex_display_scanner`.

## Test plan
Bench parameters: DIV=8, BLANK=2.
1. Reset: hold `reset`=0 for 3 cycles → `seg`=7F, `an`=3F, `cap_ack`=`frame_done`=0. After release, cycles 0–1 are blank; cycle 2 gives `an`=6'b111110, `seg`=0000001.
2. Handshake: `pc_val`=0x000000A4, `wd_val`=0x00001F3C, `cap_req`=1 raised at digit 2 → `snap` unchanged until the boundary; `cap_ack` pulses once 1 cycle after it. The next frame shows digits 5..0 = A,4,1,F,3,C (0001000, 1001100, 1001111, 0111000, 0000110, 0110001).
3. Wrap: run 200 cycles → `frame_done` every 48 cycles; `digit` sequence 0..5,0.
4. Live mode: `live`=1, `cap_req`=0, `wd_val` incremented every frame → each frame shows the value sampled at the preceding boundary; `cap_ack` stays 0.
5. Reset mid-operation: `cap_req`=1 and `reset`=0 at digit 3 → state returns to reset values; `snap`=0; no `cap_ack` ever issued for that request.
6. Simultaneous: `cap_req`=1 and `live`=1 at the boundary → a single capture, `cap_ack` pulses exactly once, `frame_done` pulses in the same cycle.
